// File: rtl/clk_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl_if
// Bundles the configuration handshake, the run/stop level and the divided
// clock outputs of clk_div_ctrl.
//   master : config master side (drives enable, cfgValid, cfgFactor)
//   slave  : the divider controller (drives everything else)
// Signals:
//   enable     run the divider (sampled only at period end while running)
//   cfgValid   a new factor is offered
//   cfgFactor  requested period in clkIn cycles
//   cfgReady   controller can accept a factor
//   cfgDone    one-cycle pulse: accepted factor is now active
//   cfgErr     one-cycle pulse: offered factor was rejected
//   clkOut     divided clock level
//   tick       one-cycle pulse on the first cycle of each period
//   busy       divider is running (with or without a pending factor)
// ----------------------------------------------------------------------------
interface clk_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             enable;
    logic             cfgValid;
    logic [WIDTH-1:0] cfgFactor;
    logic             cfgReady;
    logic             cfgDone;
    logic             cfgErr;
    logic             clkOut;
    logic             tick;
    logic             busy;

    modport master (
        output enable,
        output cfgValid,
        output cfgFactor,
        input  cfgReady,
        input  cfgDone,
        input  cfgErr,
        input  clkOut,
        input  tick,
        input  busy
    );

    modport slave (
        input  enable,
        input  cfgValid,
        input  cfgFactor,
        output cfgReady,
        output cfgDone,
        output cfgErr,
        output clkOut,
        output tick,
        output busy
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time programmable clock divider. Produces a registered divided clock
// level (clkOut) and a first-cycle-of-period pulse (tick) from clkIn. New
// factors arrive over a valid/ready handshake and, while running, are held
// until the current period ends so clkOut never shows a runt pulse. Dropping
// enable stops the divider at the end of the current period.
// Ports:
//   clkIn   system clock, all logic on its rising edge
//   resetN  synchronous active-low reset
//   bus     clk_div_ctrl_if slave modport (handshake, enable, outputs)
// Parameters:
//   WIDTH           width of factor and counter
//   DEFAULT_FACTOR  active factor after reset (>= 2)
//   MIN_FACTOR      smallest legal factor; smaller requests raise cfgErr
// ----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DEFAULT_FACTOR = 100,
    parameter int unsigned MIN_FACTOR     = 2
) (
    input  logic          clkIn,
    input  logic          resetN,
    clk_div_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] DEFAULT_F = WIDTH'(DEFAULT_FACTOR);
    localparam logic [WIDTH-1:0] MIN_F     = WIDTH'(MIN_FACTOR);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PENDING
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] counter, counter_next;
    logic [WIDTH-1:0] active_factor, active_next;
    logic [WIDTH-1:0] pending_factor, pending_next;
    logic             clk_out, clk_out_next;
    logic             tick_pulse, tick_next;
    logic             done_pulse, done_next;
    logic             err_pulse, err_next;
    logic             ready, ready_next;
    logic             busy_flag, busy_next;

    logic             transfer;
    logic             legal;
    logic             at_wrap;

    // The registered ready is the one the master sees, so the transfer
    // qualification must use it rather than anything combinational.
    assign transfer = bus.cfgValid && ready;
    assign legal    = (bus.cfgFactor >= MIN_F);
    // active_factor is always >= MIN_FACTOR >= 2, so the subtraction cannot wrap.
    assign at_wrap  = (counter == (active_factor - ONE));

    // State and output registers; reset wins over everything, including a
    // pending factor.
    always_ff @(posedge clkIn) begin
        if (!resetN) begin
            state          <= IDLE;
            counter        <= '0;
            active_factor  <= DEFAULT_F;
            pending_factor <= '0;
            clk_out        <= 1'b0;
            tick_pulse     <= 1'b0;
            done_pulse     <= 1'b0;
            err_pulse      <= 1'b0;
            ready          <= 1'b1;
            busy_flag      <= 1'b0;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            active_factor  <= active_next;
            pending_factor <= pending_next;
            clk_out        <= clk_out_next;
            tick_pulse     <= tick_next;
            done_pulse     <= done_next;
            err_pulse      <= err_next;
            ready          <= ready_next;
            busy_flag      <= busy_next;
        end
    end

    // Next-state logic. Outputs are derived from the next counter/factor so
    // that the registered outputs describe the counter value held after the
    // same edge.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        active_next  = active_factor;
        pending_next = pending_factor;
        done_next    = 1'b0;
        err_next     = 1'b0;

        // A rejected factor never alters state or the active factor.
        if (transfer && !legal) begin
            err_next = 1'b1;
        end

        case (state)
            IDLE: begin
                counter_next = '0;
                // Applying immediately also covers a transfer coinciding with
                // enable: the first period already uses the new factor.
                if (transfer && legal) begin
                    active_next = bus.cfgFactor;
                    done_next   = 1'b1;
                end
                if (bus.enable) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                counter_next = at_wrap ? '0 : (counter + ONE);
                // A legal transfer takes priority over a stop request at the
                // same wrap; enable is then sampled at the following wrap.
                if (transfer && legal) begin
                    pending_next = bus.cfgFactor;
                    state_next   = PENDING;
                end else if (at_wrap && !bus.enable) begin
                    state_next = IDLE;
                end
            end

            PENDING: begin
                counter_next = at_wrap ? '0 : (counter + ONE);
                if (at_wrap) begin
                    active_next = pending_factor;
                    done_next   = 1'b1;
                    state_next  = bus.enable ? RUN : IDLE;
                end
            end

            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase

        clk_out_next = (state_next != IDLE) && (counter_next >= (active_next >> 1));
        tick_next    = (state_next != IDLE) && (counter_next == '0);
        ready_next   = (state_next != PENDING);
        busy_next    = (state_next != IDLE);
    end

    assign bus.clkOut   = clk_out;
    assign bus.tick     = tick_pulse;
    assign bus.cfgDone  = done_pulse;
    assign bus.cfgErr   = err_pulse;
    assign bus.cfgReady = ready;
    assign bus.busy     = busy_flag;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl. A behavioural model tracks whether
// the divider runs, the position inside the current period, the active
// factor and an optional queued factor; expected outputs follow from those
// with plain arithmetic. Scenario tasks drive stimulus and compare the
// outputs {clkOut,tick,cfgDone,cfgErr,cfgReady,busy} after each edge.
// ----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned WIDTH = 32;

    logic clkIn;
    logic resetN;

    clk_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    clk_div_ctrl #(
        .WIDTH         (WIDTH),
        .DEFAULT_FACTOR(100),
        .MIN_FACTOR    (2)
    ) dut (
        .clkIn (clkIn),
        .resetN(resetN),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // behavioural model
    bit          m_run;
    int unsigned m_phase;
    int unsigned m_factor;
    bit          m_pend;
    int unsigned m_pend_factor;
    bit          e_done;
    bit          e_err;
    logic [5:0]  exp_vec;
    logic [5:0]  obs_vec;

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    // Advance one clock edge, update the model from the inputs that were
    // present at that edge, then sample the DUT 1 time unit later.
    task automatic step();
        bit xfer;
        bit legal;
        bit at_end;
        @(posedge clkIn);
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!resetN) begin
            m_run         = 1'b0;
            m_phase       = 0;
            m_factor      = 100;
            m_pend        = 1'b0;
            m_pend_factor = 0;
        end else begin
            xfer  = bus.cfgValid && !m_pend;
            legal = (bus.cfgFactor >= 2);
            if (xfer && !legal) e_err = 1'b1;
            if (!m_run) begin
                if (xfer && legal) begin
                    m_factor = bus.cfgFactor;
                    e_done   = 1'b1;
                end
                if (bus.enable) begin
                    m_run   = 1'b1;
                    m_phase = 0;
                end
            end else begin
                at_end  = (m_phase + 1 == m_factor);
                m_phase = at_end ? 0 : m_phase + 1;
                if (m_pend) begin
                    if (at_end) begin
                        m_factor = m_pend_factor;
                        m_pend   = 1'b0;
                        e_done   = 1'b1;
                        if (!bus.enable) m_run = 1'b0;
                    end
                end else if (xfer && legal) begin
                    m_pend        = 1'b1;
                    m_pend_factor = bus.cfgFactor;
                end else if (at_end && !bus.enable) begin
                    m_run = 1'b0;
                end
                if (!m_run) m_phase = 0;
            end
        end
        #1;
        cyc++;
        exp_vec = {m_run && (m_phase >= m_factor / 2), m_run && (m_phase == 0),
                   e_done, e_err, !m_pend, m_run};
        obs_vec = {bus.clkOut, bus.tick, bus.cfgDone, bus.cfgErr, bus.cfgReady, bus.busy};
    endtask

    // Stop the divider and wait (bounded) until the model reports idle.
    task automatic settle_idle();
        bus.enable   = 1'b0;
        bus.cfgValid = 1'b0;
        for (int i = 0; i < 300 && m_run; i++) step();
    endtask

    task automatic test_reset();
        int highs;
        int ticks;
        resetN        = 1'b0;
        bus.enable    = 1'b0;
        bus.cfgValid  = 1'b0;
        bus.cfgFactor = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
            end
        end
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vec !== 6'b000010) begin
                n_fail++;
                $display("[TB] FAIL idle_after_reset cyc=%0d got=%b exp=%b", cyc, obs_vec, 6'b000010);
            end
        end
        bus.enable = 1'b1;
        highs = 0;
        ticks = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            highs += int'(bus.clkOut);
            ticks += int'(bus.tick);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL default_run cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (highs != 100 || ticks != 2) begin
            n_fail++;
            $display("[TB] FAIL default_period got highs=%0d ticks=%0d exp highs=100 ticks=2", highs, ticks);
        end
    endtask

    task automatic test_idle_config();
        settle_idle();
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 5;
        step();
        bus.cfgValid = 1'b0;
        n_checks++;
        if (bus.cfgDone !== 1'b1 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL idle_cfg_done cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec || bus.clkOut !== ((i % 5) >= 2) || bus.tick !== ((i % 5) == 0)) begin
                n_fail++;
                $display("[TB] FAIL odd_factor_wave i=%0d got=%b exp=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_boundary_switch();
        logic [7:0] wave;
        int         done_tick_at;
        settle_idle();
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 4;
        bus.enable    = 1'b1;
        step();
        bus.cfgValid = 1'b0;
        step();
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 6;
        step();
        bus.cfgValid = 1'b0;
        n_checks++;
        if (bus.cfgReady !== 1'b0 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL switch_ready_drop cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
        end
        wave         = '0;
        done_tick_at = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            wave = {wave[6:0], bus.clkOut};
            if (bus.cfgDone && bus.tick && done_tick_at < 0) done_tick_at = i;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL switch_run cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (wave !== 8'b1000_1110 || done_tick_at != 1) begin
            n_fail++;
            $display("[TB] FAIL switch_wave got=%b done_at=%0d exp=10001110 done_at=1", wave, done_tick_at);
        end
    endtask

    task automatic test_clean_stop();
        int ticks_after;
        settle_idle();
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 8;
        bus.enable    = 1'b1;
        step();
        bus.cfgValid = 1'b0;
        step();
        step();
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec || bus.clkOut !== (i >= 1) || bus.busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL stop_finish_period i=%0d got=%b exp=%b", i, obs_vec, exp_vec);
            end
        end
        ticks_after = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ticks_after += int'(bus.tick);
            n_checks++;
            if (obs_vec !== exp_vec || obs_vec !== 6'b000010) begin
                n_fail++;
                $display("[TB] FAIL stop_idle i=%0d got=%b exp=%b", i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (ticks_after != 0) begin
            n_fail++;
            $display("[TB] FAIL stop_no_ticks got=%0d exp=0", ticks_after);
        end
    endtask

    task automatic test_reject();
        int dones;
        int errs;
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 4;
        bus.enable    = 1'b1;
        step();
        bus.cfgValid = 1'b0;
        step();
        step();
        dones = 0;
        errs  = 0;
        for (int i = 0; i < 16; i++) begin
            bus.cfgValid  = (i == 0) || (i == 3);
            bus.cfgFactor = (i == 0) ? 1 : 0;
            step();
            dones += int'(bus.cfgDone);
            errs  += int'(bus.cfgErr);
            n_checks++;
            if (obs_vec !== exp_vec || bus.cfgErr !== ((i == 0) || (i == 3))) begin
                n_fail++;
                $display("[TB] FAIL reject_run i=%0d got=%b exp=%b", i, obs_vec, exp_vec);
            end
        end
        bus.cfgValid = 1'b0;
        n_checks++;
        if (dones != 0 || errs != 2) begin
            n_fail++;
            $display("[TB] FAIL reject_counts got done=%0d err=%0d exp done=0 err=2", dones, errs);
        end
    endtask

    task automatic test_reset_mid();
        int highs;
        // the divider still runs with factor 4 from the reject scenario
        bus.cfgValid  = 1'b1;
        bus.cfgFactor = 10;
        step();
        bus.cfgValid = 1'b0;
        n_checks++;
        if (bus.cfgReady !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_pending got ready=%b busy=%b exp ready=0 busy=1", bus.cfgReady, bus.busy);
        end
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        n_checks++;
        if (obs_vec !== 6'b000010 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_idle got=%b exp=%b", obs_vec, 6'b000010);
        end
        highs = 0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (i < 100) highs += int'(bus.clkOut);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_run cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (highs != 50) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_factor got highs=%0d exp=50", highs);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            bus.enable    = ($urandom_range(0, 9) != 0);
            bus.cfgValid  = ($urandom_range(0, 4) == 0);
            bus.cfgFactor = $urandom_range(0, 9);
            step();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL random_run cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
            end
        end
        bus.cfgValid = 1'b0;
    endtask

    initial begin
        resetN        = 1'b0;
        bus.enable    = 1'b0;
        bus.cfgValid  = 1'b0;
        bus.cfgFactor = '0;
        test_reset();
        test_idle_config();
        test_boundary_switch();
        test_clean_stop();
        test_reject();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time programmable clock-divider controller. It generates a divided clock-level output and a per-period tick from clkIn. It accepts new division factors over a valid/ready handshake and applies each one only at a period boundary, so clkOut never shows a runt pulse. It also gates the divider on and off cleanly. It sits between a config master (register block or FSM) and the logic consuming the slow clock or tick.

Parameters:
WIDTH, 32, width of the factor and counter.
DEFAULT_FACTOR, 100, active factor after reset; must be >= 2.
MIN_FACTOR, 2, smallest legal factor; smaller requests are rejected.

Ports:
clkIn  input  1  system clock; all logic on its posedge.
resetN  input  1  synchronous active-low reset.
enable  input  1  level; high = run the divider, low = stop at the next period end.
cfgValid  input  1  a new factor is offered.
cfgFactor  input  WIDTH  requested period in clkIn cycles.
cfgReady  output  1  controller can accept a factor.
cfgDone  output  1  one-cycle pulse: the accepted factor is now active.
cfgErr  output  1  one-cycle pulse: the offered factor was rejected (< MIN_FACTOR).
clkOut  output  1  divided clock level (registered).
tick  output  1  one-cycle pulse on the first cycle of each period.
busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (resetN=0 at posedge): state=IDLE, counter=0, activeFactor=DEFAULT_FACTOR, pending register=0. Outputs: clkOut=0, tick=0, cfgDone=0, cfgErr=0, busy=0, cfgReady=1. Reset overrides everything, including mid-period and mid-pending operation; any pending factor is discarded.
- Period definition: with factor F, the counter runs 0..F-1 and then wraps to 0. clkOut=0 for counter < F/2 (floor) and clkOut=1 otherwise. So F=4 gives 0011 and F=5 gives 00111.
- All outputs are registered. clkOut and tick reflect the counter value held after the same edge. tick=1 iff running and counter==0.
- Handshake: a transfer occurs on a posedge with cfgValid=1 and cfgReady=1. cfgReady=0 only in PENDING. cfgValid with cfgReady=0 is ignored; the master holds it.
- Rejection: a transfer with cfgFactor < MIN_FACTOR produces a cfgErr pulse on the next cycle. activeFactor and state are unchanged.
- States:
  - IDLE: counter=0, clkOut=0.
    - Legal transfer: activeFactor<=cfgFactor, with cfgDone pulsed the next cycle.
    - enable=1: go to RUN, with counter=0 and tick=1 on the next cycle.
    - Transfer and enable in the same cycle: the new factor is used from the first period.
  - RUN: the counter increments each cycle.
    - Legal transfer: latch into the pending register and go to PENDING.
    - At wrap (counter==activeFactor-1) with enable=0: go to IDLE, counter=0, clkOut=0.
    - A legal transfer in the same cycle as a wrap goes to PENDING and applies at the following wrap.
  - PENDING: the counter keeps running with the old activeFactor.
    - At wrap: activeFactor<=pending, counter<=0, cfgDone=1 and tick=1 in that same next cycle. Then go to RUN if enable=1, or to IDLE (no tick) if enable=0.
- enable is sampled only at wrap while RUN or PENDING. Toggling enable mid-period has no effect unless it is low at the wrap.
- Counter comparisons use WIDTH-bit unsigned arithmetic. Factors up to 2^WIDTH-1 are legal, and the counter never overflows.
- busy=1 in RUN and PENDING.

Test Plan:
- Reset defaults: hold resetN=0 for 3 cycles, release with enable=0 -> clkOut=0, tick=0, cfgReady=1, busy=0. Then raise enable -> period 100 with 50 low and 50 high cycles, tick every 100 cycles.
- Config in IDLE plus odd factor: offer cfgFactor=5, then enable -> cfgDone 1 cycle after the transfer; clkOut pattern 0,0,1,1,1 repeating; tick on every counter==0.
- Boundary switch: running F=4, offer F=6 at counter=1 -> cfgReady drops, F=4 period completes (0011), then cfgDone=tick=1 together and the next period is 000111.
- Clean stop: running F=8, drop enable at counter=2 -> the current period finishes (0000 then 1111), then IDLE with clkOut=0, busy=0, and no further ticks.
- Reject: offer cfgFactor=1, then 0 -> cfgErr pulses 1 cycle after each transfer; activeFactor and the output waveform are unchanged; cfgDone never pulses.
- Reset mid-operation: resetN=0 while in PENDING with F=4 active and F=10 pending -> next cycle IDLE, activeFactor=100, pending discarded, cfgReady=1.
